// File: rtl/uart_hex_display.sv
// 8N1 UART receiver that shifts received ASCII hex digits into an N-digit buffer,
// scanned one digit at a time onto shared 7-segment lines.
module uart_hex_display #(
  parameter int CLKS_PER_BIT   = 234,
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 27000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SC_W  = $clog2(SCAN_DIV);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // XOR masks: all-ones inverts the active-high value for active-low boards.
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_e;

  logic                  sync1_q, sync2_q;
  logic                  rxs;
  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;

  logic [3:0]            nib_q [NUM_DIGITS];
  logic [3:0]            nib_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] on_q, on_d;
  logic                  is_hex;
  logic [3:0]            hex_nib;

  logic [SC_W-1:0]       sc_q, sc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign rxs = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Letters 'A'-'F' and 'a'-'f' share low nibbles 1..6, so +9 yields 10..15.
  always_comb begin
    is_hex  = 1'b0;
    hex_nib = data_q[3:0];
    if (data_q >= 8'h30 && data_q <= 8'h39) begin
      is_hex = 1'b1;
    end else if ((data_q >= 8'h41 && data_q <= 8'h46) ||
                 (data_q >= 8'h61 && data_q <= 8'h66)) begin
      is_hex  = 1'b1;
      hex_nib = data_q[3:0] + 4'd9;
    end
  end

  always_comb begin
    nib_d = nib_q;
    on_d  = on_q;
    if (valid_q) begin
      if (is_hex) begin
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
          nib_d[k] = nib_q[k-1];
          on_d[k]  = on_q[k-1];
        end
        nib_d[0] = hex_nib;
        on_d[0]  = 1'b1;
      end else if (data_q == 8'h1B) begin
        on_d = '0;
      end
    end
  end

  always_comb begin
    sc_d  = sc_q + 1'b1;
    idx_d = idx_q;
    if (sc_q == SC_LAST) begin
      sc_d  = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    seg_d = (on_q[idx_q] ? hex7(nib_q[idx_q]) : 7'h00) ^ SEG_OFF;
    an_d  = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      nib_q   <= '{default: '0};
      on_q    <= '0;
      sc_q    <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      nib_q   <= nib_d;
      on_q    <= on_d;
      sc_q    <= sc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_hex_display.sv
// Directed bench for uart_hex_display: two instances (seg active-high / active-low)
// share clock, reset and serial line.
module tb_uart_hex_display;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [6:0] seg, seg_n;
  logic [3:0] an, an_n;
  logic [7:0] rx_data, rx_data_n;
  logic       rx_valid, rx_valid_n, frame_err, frame_err_n;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  int fcnt  = 0;
  bit both_seen = 1'b0;

  always #5 clk = ~clk;

  uart_hex_display #(
    .CLKS_PER_BIT(CPB), .NUM_DIGITS(4), .SCAN_DIV(4),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .seg(seg), .an(an),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
  );

  uart_hex_display #(
    .CLKS_PER_BIT(CPB), .NUM_DIGITS(4), .SCAN_DIV(4),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0)
  ) dut_n (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .seg(seg_n), .an(an_n),
    .rx_data(rx_data_n), .rx_valid(rx_valid_n), .frame_err(frame_err_n)
  );

  always @(negedge clk) begin
    if (rx_valid === 1'b1) vcnt++;
    if (frame_err === 1'b1) fcnt++;
    if (rx_valid === 1'b1 && frame_err === 1'b1) both_seen = 1'b1;
  end

  // low_bits == 0: normal stop bit; otherwise line held low for that many bit periods.
  task automatic send_frame(input logic [7:0] b, input int low_bits);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (low_bits == 0) begin
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      uart_rx = 1'b0;
      repeat (CPB * low_bits) @(negedge clk);
      uart_rx = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_digits(input string name, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] ex [4];
    logic [3:0] want;
    bit found;
    ex = '{e0, e1, e2, e3};
    for (int d = 0; d < 4; d++) begin
      want  = 4'b0001 << d;
      found = 1'b0;
      for (int i = 0; i < 24 && !found; i++) begin
        @(negedge clk);
        if (an === want) found = 1'b1;
      end
      total++;
      if (!found) begin
        bad++;
        $display("FAIL %s an timeout: got %b want %b", name, an, want);
      end else begin
        total++;
        if (seg !== ex[d]) begin
          bad++;
          $display("FAIL %s digit%0d seg: got %h want %h", name, d, seg, ex[d]);
        end
        total++;
        if (seg_n !== ~ex[d]) begin
          bad++;
          $display("FAIL %s digit%0d seg_n: got %h want %h", name, d, seg_n, ~ex[d]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (seg !== 7'h00) begin bad++; $display("FAIL reset seg: got %h want 00", seg); end
    total++; if (seg_n !== 7'h7F) begin bad++; $display("FAIL reset seg_n: got %h want 7f", seg_n); end
    total++; if (an !== 4'b0000) begin bad++; $display("FAIL reset an: got %b want 0000", an); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset rx_data: got %h want 00", rx_data); end
    total++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
      bad++; $display("FAIL reset pulses: got %b%b want 00", rx_valid, frame_err);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_char();
    int v0;
    v0 = vcnt;
    send_frame(8'h35, 0);
    total++; if (vcnt - v0 != 1) begin bad++; $display("FAIL char5 valid count: got %0d want 1", vcnt - v0); end
    total++; if (rx_data !== 8'h35) begin bad++; $display("FAIL char5 rx_data: got %h want 35", rx_data); end
    check_digits("char5", 7'h00, 7'h00, 7'h00, 7'h6D);
  endtask

  task automatic test_shift_scan();
    logic [7:0] s [5];
    logic [3:0] prev;
    bit found;
    int n;
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41};
    for (int i = 0; i < 5; i++) send_frame(s[i], 0);
    total++; if (rx_data !== 8'h41) begin bad++; $display("FAIL shift rx_data: got %h want 41", rx_data); end
    check_digits("shift", 7'h5B, 7'h4F, 7'h66, 7'h77);
    prev = an;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an === 4'b0001 && prev !== 4'b0001) found = 1'b1;
      prev = an;
    end
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      n++;
      if (an === 4'b0001 && prev !== 4'b0001) found = 1'b1;
      prev = an;
    end
    total++; if (!found || n != 16) begin bad++; $display("FAIL scan period: got %0d want 16", n); end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    v0 = vcnt; f0 = fcnt;
    send_frame(8'h41, 41);
    total++; if (fcnt - f0 != 1) begin bad++; $display("FAIL ferr count: got %0d want 1", fcnt - f0); end
    total++; if (vcnt - v0 != 0) begin bad++; $display("FAIL ferr valid count: got %0d want 0", vcnt - v0); end
    total++; if (rx_data !== 8'h41) begin bad++; $display("FAIL ferr rx_data: got %h want 41", rx_data); end
    check_digits("ferr_hold", 7'h5B, 7'h4F, 7'h66, 7'h77);
    repeat (20) @(negedge clk);
    v0 = vcnt;
    send_frame(8'h39, 0);
    total++; if (vcnt - v0 != 1) begin bad++; $display("FAIL after-ferr valid: got %0d want 1", vcnt - v0); end
    total++; if (rx_data !== 8'h39) begin bad++; $display("FAIL after-ferr rx_data: got %h want 39", rx_data); end
    check_digits("after_ferr", 7'h4F, 7'h66, 7'h77, 7'h6F);
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = vcnt; f0 = fcnt;
    uart_rx = 1'b0;
    repeat (6) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (vcnt != v0 || fcnt != f0) begin
      bad++; $display("FAIL glitch pulses: got v=%0d f=%0d want 0 0", vcnt - v0, fcnt - f0);
    end
    send_frame(8'h37, 0);
    total++; if (vcnt - v0 != 1) begin bad++; $display("FAIL glitch next valid: got %0d want 1", vcnt - v0); end
    total++; if (rx_data !== 8'h37) begin bad++; $display("FAIL glitch next rx_data: got %h want 37", rx_data); end
    check_digits("glitch", 7'h66, 7'h77, 7'h6F, 7'h07);
  endtask

  task automatic test_other_esc();
    int v0;
    v0 = vcnt;
    send_frame(8'h5A, 0);
    total++; if (vcnt - v0 != 1) begin bad++; $display("FAIL Z valid: got %0d want 1", vcnt - v0); end
    total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL Z rx_data: got %h want 5a", rx_data); end
    check_digits("Z", 7'h66, 7'h77, 7'h6F, 7'h07);
    send_frame(8'h1B, 0);
    total++; if (rx_data !== 8'h1B) begin bad++; $display("FAIL esc rx_data: got %h want 1b", rx_data); end
    check_digits("esc", 7'h00, 7'h00, 7'h00, 7'h00);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int v0, f0;
    b = 8'h66;
    send_frame(8'h31, 0);
    v0 = vcnt; f0 = fcnt;
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (seg !== 7'h00 || seg_n !== 7'h7F) begin
      bad++; $display("FAIL midrst seg: got %h/%h want 00/7f", seg, seg_n);
    end
    total++; if (an !== 4'b0000) begin bad++; $display("FAIL midrst an: got %b want 0000", an); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midrst rx_data: got %h want 00", rx_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    uart_rx = 1'b1;
    repeat (CPB * 8) @(negedge clk);
    total++; if (vcnt != v0 || fcnt != f0) begin
      bad++; $display("FAIL midrst pulses: got v=%0d f=%0d want 0 0", vcnt - v0, fcnt - f0);
    end
    check_digits("midrst_blank", 7'h00, 7'h00, 7'h00, 7'h00);
    send_frame(8'h66, 0);
    total++; if (rx_data !== 8'h66) begin bad++; $display("FAIL f rx_data: got %h want 66", rx_data); end
    check_digits("f", 7'h00, 7'h00, 7'h00, 7'h71);
  endtask

  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    test_reset();
    test_single_char();
    test_shift_scan();
    test_frame_error();
    test_glitch();
    test_other_esc();
    test_reset_midframe();
    total++;
    if (both_seen) begin bad++; $display("FAIL exclusive pulses: got both want never"); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
